// File: rtl/rmw_decode_sequencer_if.sv
// Bus bundle between the RMW shift-group sequencer and the 6502-style datapath.
// master = sequencer side (drives control outputs), slave = datapath/bus side.
interface rmw_decode_sequencer_if #(
    parameter int ADDR_W   = 16,
    parameter int STATUS_W = 7
) ();
    logic                rdy;
    logic [7:0]          instruction;
    logic                sync;
    logic                pc_enable;
    logic                address_select;
    logic [ADDR_W-1:0]   memory_address;
    logic                rw;
    logic [1:0]          input_data_latch_enable;
    logic [1:0]          data_buffer_enable;
    logic [2:0]          alu_enable;
    logic [2:0]          accumulator_enable;
    logic                processor_status_register_rw;
    logic [STATUS_W-1:0] processor_status_register_write;

    modport master (
        input  rdy, instruction,
        output sync, pc_enable, address_select, memory_address, rw,
               input_data_latch_enable, data_buffer_enable, alu_enable,
               accumulator_enable, processor_status_register_rw,
               processor_status_register_write
    );

    modport slave (
        output rdy, instruction,
        input  sync, pc_enable, address_select, memory_address, rw,
               input_data_latch_enable, data_buffer_enable, alu_enable,
               accumulator_enable, processor_status_register_rw,
               processor_status_register_write
    );
endinterface

// File: rtl/rmw_decode_sequencer.sv
// Cycle sequencer for the shift group (ASL/ROL/LSR/ROR) in zpg, abs and accumulator modes.
// Abs mode is built only when RMW_ABS_MODE_EN is defined; otherwise bbb=011 runs as a NOP.
module rmw_decode_sequencer #(
    parameter int ADDR_W   = 16,
    parameter int STATUS_W = 7
) (
    input  logic                  clk,
    input  logic                  res,
    rmw_decode_sequencer_if.master bus
);

    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ASL  = 3'd1;
    localparam logic [2:0] ALU_ROL  = 3'd2;
    localparam logic [2:0] ALU_LSR  = 3'd3;
    localparam logic [2:0] ALU_ROR  = 3'd4;

    // Status bit order is C,Z,I,D,B,V,N from bit 0, so C|Z|N = bits 0,1,6.
    localparam logic [STATUS_W-1:0] FLAG_CZN = STATUS_W'(7'h43);

    typedef enum logic [1:0] {
        M_NOP,
        M_ZPG,
        M_ABS,
        M_ACC
    } mode_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_ADL,
        S_ADH,
        S_READ,
        S_MODIFY,
        S_WRITE,
        S_ACC_RD,
        S_ACC_WB
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] opcode;
    logic [7:0] adl;
    logic [7:0] adh;
    logic       booted;
    mode_t      op_mode;
    logic [2:0] alu_op;

    function automatic mode_t decode(input logic [7:0] op);
        mode_t m;
        m = M_NOP;
        if (op[1:0] == 2'b10 && op[7] == 1'b0) begin
            case (op[4:2])
                3'b001:  m = M_ZPG;
                3'b010:  m = M_ACC;
`ifdef RMW_ABS_MODE_EN
                3'b011:  m = M_ABS;
`endif
                default: m = M_NOP;
            endcase
        end
        return m;
    endfunction

    assign op_mode = decode(opcode);

    always_comb begin
        case (opcode[6:5])
            2'b00:   alu_op = ALU_ASL;
            2'b01:   alu_op = ALU_ROL;
            2'b10:   alu_op = ALU_LSR;
            2'b11:   alu_op = ALU_ROR;
            default: alu_op = ALU_NONE;
        endcase
    end

    // Zero page never carries into the high byte, so adh is masked off there.
    assign bus.memory_address = ADDR_W'({(op_mode == M_ABS) ? adh : 8'h00, adl});

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state  <= S_IDLE;
            opcode <= 8'hEA;
            adl    <= 8'h00;
            adh    <= 8'h00;
            booted <= 1'b0;
        end else begin
            state  <= state_nxt;
            booted <= 1'b1;
            if (state == S_FETCH && bus.rdy) opcode <= bus.instruction;
            if (state == S_ADL && bus.rdy)   adl    <= bus.instruction;
`ifdef RMW_ABS_MODE_EN
            if (state == S_ADH && bus.rdy)   adh    <= bus.instruction;
`endif
        end
    end

    always_comb begin
        state_nxt                           = state;
        bus.sync                            = 1'b0;
        bus.pc_enable                       = 1'b0;
        bus.address_select                  = 1'b0;
        bus.rw                              = 1'b1;
        bus.input_data_latch_enable         = 2'b00;
        bus.data_buffer_enable              = 2'b00;
        bus.alu_enable                      = ALU_NONE;
        bus.accumulator_enable              = 3'b000;
        bus.processor_status_register_rw    = 1'b1;
        bus.processor_status_register_write = '0;

        case (state)
            // The first edge after reset release is spent in IDLE.
            S_IDLE: begin
                if (bus.rdy && booted) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                bus.sync      = 1'b1;
                bus.pc_enable = 1'b1;
                if (bus.rdy) begin
                    case (decode(bus.instruction))
                        M_ZPG, M_ABS: state_nxt = S_ADL;
                        M_ACC:        state_nxt = S_ACC_RD;
                        default:      state_nxt = S_IDLE;
                    endcase
                end
            end
            S_ADL: begin
                bus.pc_enable = 1'b1;
                if (bus.rdy) state_nxt = (op_mode == M_ABS) ? S_ADH : S_READ;
            end
            S_ADH: begin
                bus.pc_enable = 1'b1;
                if (bus.rdy) state_nxt = S_READ;
            end
            S_READ: begin
                bus.address_select          = 1'b1;
                bus.input_data_latch_enable = 2'b01;
                if (bus.rdy) state_nxt = S_MODIFY;
            end
            // Dummy write of the unmodified byte while the ALU works.
            S_MODIFY: begin
                bus.address_select                  = 1'b1;
                bus.rw                              = 1'b0;
                bus.input_data_latch_enable         = 2'b10;
                bus.data_buffer_enable              = 2'b01;
                bus.alu_enable                      = alu_op;
                bus.processor_status_register_rw    = 1'b0;
                bus.processor_status_register_write = FLAG_CZN;
                state_nxt                           = S_WRITE;
            end
            S_WRITE: begin
                bus.address_select     = 1'b1;
                bus.rw                 = 1'b0;
                bus.data_buffer_enable = 2'b10;
                state_nxt              = S_FETCH;
            end
            S_ACC_RD: begin
                bus.accumulator_enable              = 3'b110;
                bus.alu_enable                      = alu_op;
                bus.processor_status_register_rw    = 1'b0;
                bus.processor_status_register_write = FLAG_CZN;
                state_nxt                           = S_ACC_WB;
            end
            S_ACC_WB: begin
                bus.accumulator_enable = 3'b100;
                state_nxt              = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rmw_decode_sequencer.sv
// Directed bench for rmw_decode_sequencer; per-cycle control word and address checks.
module tb_rmw_decode_sequencer;

    logic clk;
    logic res;
    int   checks;
    int   fails;

    rmw_decode_sequencer_if #(.ADDR_W(16), .STATUS_W(7)) bus ();

    rmw_decode_sequencer #(.ADDR_W(16), .STATUS_W(7)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] ASL = 3'd1;
    localparam logic [2:0] ROL = 3'd2;
    localparam logic [2:0] LSR = 3'd3;
    localparam logic [2:0] ROR = 3'd4;

    // {sync,pc,asel,rw,idl[2],dbe[2],alu[3],acc[3],psr_rw,mask[7]}
    localparam logic [21:0] E_IDLE  = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'd0, 3'b000, 1'b1, 7'h00};
    localparam logic [21:0] E_FETCH = {1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 3'd0, 3'b000, 1'b1, 7'h00};
    localparam logic [21:0] E_ADDR  = {1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 3'd0, 3'b000, 1'b1, 7'h00};
    localparam logic [21:0] E_READ  = {1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 3'd0, 3'b000, 1'b1, 7'h00};
    localparam logic [21:0] E_WRITE = {1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 3'd0, 3'b000, 1'b1, 7'h00};
    localparam logic [21:0] E_ACCWB = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'd0, 3'b100, 1'b1, 7'h00};

    function automatic logic [21:0] e_modify(input logic [2:0] alu);
        return {1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, alu, 3'b000, 1'b0, 7'h43};
    endfunction

    function automatic logic [21:0] e_accrd(input logic [2:0] alu);
        return {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, alu, 3'b110, 1'b0, 7'h43};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [21:0] exp);
        logic [21:0] obs;
        obs = {bus.sync, bus.pc_enable, bus.address_select, bus.rw,
               bus.input_data_latch_enable, bus.data_buffer_enable,
               bus.alu_enable, bus.accumulator_enable,
               bus.processor_status_register_rw,
               bus.processor_status_register_write};
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s ctrl observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input logic [15:0] exp);
        checks++;
        assert (bus.memory_address === exp) else begin
            fails++;
            $error("FAIL %s addr observed=%h expected=%h", tag, bus.memory_address, exp);
        end
    endtask

    initial begin
        checks          = 0;
        fails           = 0;
        res             = 1'b1;
        bus.rdy         = 1'b1;
        bus.instruction = 8'h00;

        // Reset state
        tick();
        tick();
        chk("reset_ctrl", E_IDLE);
        chk_addr("reset_addr", 16'h0000);
        @(negedge clk) res = 1'b0;

        tick();
        chk("boot_idle", E_IDLE);
        tick();
        bus.instruction = 8'h06;
        chk("asl_zpg_fetch", E_FETCH);

        // ASL zpg 0x42
        tick(); bus.instruction = 8'h42; chk("asl_zpg_adl", E_ADDR);
        tick(); bus.instruction = 8'h00; chk("asl_zpg_read", E_READ);
        chk_addr("asl_zpg_read_addr", 16'h0042);
        tick(); chk("asl_zpg_modify", e_modify(ASL));
        chk_addr("asl_zpg_modify_addr", 16'h0042);
        tick(); chk("asl_zpg_write", E_WRITE);
        chk_addr("asl_zpg_write_addr", 16'h0042);

        // LSR A
        tick(); bus.instruction = 8'h4A; chk("lsr_acc_fetch", E_FETCH);
        tick(); bus.instruction = 8'h00; chk("lsr_acc_rd", e_accrd(LSR));
        tick(); chk("lsr_acc_wb", E_ACCWB);

        // LDA # (non-shift) runs as a NOP
        tick(); bus.instruction = 8'hA9; chk("nop_fetch", E_FETCH);
        tick(); bus.instruction = 8'h00; chk("nop_idle", E_IDLE);

        // ROR abs 0x1234
        tick(); bus.instruction = 8'h6E; chk("ror_abs_fetch", E_FETCH);
`ifdef RMW_ABS_MODE_EN
        tick(); bus.instruction = 8'h34; chk("ror_abs_adl", E_ADDR);
        tick(); bus.instruction = 8'h12; chk("ror_abs_adh", E_ADDR);
        tick(); bus.instruction = 8'h00; chk("ror_abs_read", E_READ);
        chk_addr("ror_abs_read_addr", 16'h1234);
        tick(); chk("ror_abs_modify", e_modify(ROR));
        chk_addr("ror_abs_modify_addr", 16'h1234);
        tick(); chk("ror_abs_write", E_WRITE);
`else
        tick(); bus.instruction = 8'h34; chk("abs_off_idle", E_IDLE);
`endif

        // ROL zpg with a 3-cycle stall in ADL, then rdy low in MODIFY
        tick(); bus.instruction = 8'h26; chk("rol_zpg_fetch", E_FETCH);
        tick(); bus.rdy = 1'b0; bus.instruction = 8'h55; chk("rol_stall0", E_ADDR);
        tick(); bus.instruction = 8'h66; chk("rol_stall1", E_ADDR);
        tick(); bus.instruction = 8'h88; chk("rol_stall2", E_ADDR);
        tick(); bus.rdy = 1'b1; bus.instruction = 8'h77; chk("rol_adl_release", E_ADDR);
        tick(); bus.instruction = 8'h00; chk("rol_read", E_READ);
        chk_addr("rol_read_addr", 16'h0077);
        tick(); bus.rdy = 1'b0; chk("rol_modify", e_modify(ROL));
        tick(); chk("rol_write_no_stall", E_WRITE);
        bus.rdy = 1'b1;

        // ASL zpg 0x10 aborted by reset in WRITE
        tick(); bus.instruction = 8'h06; chk("abort_fetch", E_FETCH);
        tick(); bus.instruction = 8'h10; chk("abort_adl", E_ADDR);
        tick(); bus.instruction = 8'h00; chk("abort_read", E_READ);
        tick(); chk("abort_modify", e_modify(ASL));
        tick(); chk("abort_write", E_WRITE);
        #2 res = 1'b1;
        #1 chk("abort_async_defaults", E_IDLE);
        chk_addr("abort_async_addr", 16'h0000);
        tick(); chk("abort_hold", E_IDLE);
        @(negedge clk) res = 1'b0;
        tick(); chk("abort_release_idle", E_IDLE);
        tick(); chk("abort_release_fetch", E_FETCH);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/rmw_decode_sequencer.md
RMW_DECODE_SEQUENCER -- requirements
Module: rmw_decode_sequencer

Interface
REQ-001 Parameter ADDR_W, default 16, is the memory_address width; the minimum legal value is 16 and upper bits above 16 are driven 0.
REQ-002 Parameter STATUS_W, default 7, is the processor status mask width.
REQ-003 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 Port res, input, 1: reset, asynchronous and active-high.
REQ-005 Port rdy, input, 1: 0 stalls read cycles (see REQ-019).
REQ-006 Port instruction, input, 8: data bus byte (opcode or operand) valid in the current cycle.
REQ-007 Port sync, output, 1: high during an opcode fetch cycle.
REQ-008 Port pc_enable, output, 1: increments the PC this cycle.
REQ-009 Port address_select, output, 1: 1 selects memory_address for the address bus; 0 selects the PC.
REQ-010 Port memory_address, output, ADDR_W: effective operand address.
REQ-011 Port rw, output, 1: 1 read, 0 write.
REQ-012 Ports input_data_latch_enable and data_buffer_enable, output, 2 each: 00 idle, 01 load, 10 store.
REQ-013 Port alu_enable, output, 3: ALU op code from the team ALU op header (ASL, ROL, LSR, ROR); 0 means none.
REQ-014 Port accumulator_enable, output, 3: bit2 enable, bit1 R/W_n, bit0 bus select.
REQ-015 Ports processor_status_register_rw, output, 1 (0 = write), and processor_status_register_write, output, STATUS_W: flag update mask.

Function
REQ-016 The block decodes the shift group (cc=10, aaa 000 ASL, 001 ROL, 010 LSR, 011 ROR) in three modes: bbb=001 zpg, bbb=011 abs, bbb=010 accumulator; every other opcode is a 2-cycle NOP (FETCH, IDLE).
REQ-017 States and transitions:
- IDLE -> FETCH
- FETCH: sync=1, pc_enable=1; opcode latched; next state ADL (zpg/abs), ACC_RD (acc) or IDLE (NOP)
- ADL: pc_enable=1, adl<=instruction; next state ADH (abs) or READ (zpg)
- ADH: pc_enable=1, adh<=instruction; next state READ
- READ: address_select=1, input_data_latch_enable=01; next state MODIFY
- MODIFY: address_select=1, rw=0 (dummy write of unmodified data), input_data_latch_enable=10, data_buffer_enable=01, alu_enable=op, status write; next state WRITE
- WRITE: address_select=1, rw=0, data_buffer_enable=10; next state FETCH
- ACC_RD: accumulator_enable=110, alu_enable=op, status write; next state ACC_WB
- ACC_WB: accumulator_enable=100; next state FETCH
REQ-018 memory_address is {0, adl} in zpg mode and {adh, adl} in abs mode, held from READ through WRITE; zpg never carries into the high byte.
REQ-019 When rdy=0 in FETCH, ADL, ADH, READ or IDLE, state and latched registers hold and outputs repeat; rdy is ignored in MODIFY, WRITE, ACC_RD and ACC_WB.
REQ-020 A status write sets processor_status_register_rw=0 and processor_status_register_write=C|Z|N mask; all other cycles drive rw=1 and mask=0.
REQ-021 Outputs not listed for a state take defaults: rw=1, address_select=0, all enables 0, processor_status_register_rw=1.
REQ-022 Cycle counts: zpg 5, abs 6, acc 3, NOP 2.

Reset
REQ-023 While res=1: state=IDLE, opcode=NOP (0xEA), adl=adh=0, and all outputs at REQ-021 defaults with sync=0.
REQ-024 res asserted mid-instruction, including WRITE, aborts on assertion; rw returns to 1 immediately, so no write completes.
REQ-025 After res deasserts, the first edge enters IDLE->FETCH sequence (FETCH on second edge).

Configuration
REQ-026 Macro RMW_ABS_MODE_EN: when defined, abs mode works per REQ-017; when undefined, bbb=011 opcodes decode as NOP, ADH is unreachable, and adh stays 0.

Verification
REQ-027 Opcode 0x06, operand 0x42 -> READ/MODIFY/WRITE at memory_address 0x0042, alu_enable=ASL, rw=0 for exactly 2 cycles, next FETCH at 5th cycle.
REQ-028 Opcode 0x6E, operands 0x34,0x12 (macro defined) -> memory_address 0x1234, alu_enable=ROR, 6 cycles; macro undefined -> 2-cycle NOP, no rw=0.
REQ-029 Opcode 0x4A -> ACC_RD with accumulator_enable=110, alu_enable=LSR, status mask C|Z|N; ACC_WB 100; FETCH 3 cycles after opcode.
REQ-030 rdy=0 for 3 cycles during ADL of 0x26 -> state held, pc_enable repeats, adl captured on release; rdy=0 in MODIFY -> no stall.
REQ-031 res pulsed during WRITE of 0x06 -> rw=1 asynchronously, outputs at defaults, FETCH resumes 2 edges after release.
REQ-032 Opcode 0xA9 (non-shift) -> sync, IDLE, sync again 2 cycles later; no address_select, no status write.
